alien_clear_engine: RTL and testbench
=====================================

Name: alien_clear_engine

Overview:
- Pixel engine that services the alien manager's kill and move-down requests on the frame-buffer side.
- Owns the alien row's on-screen image:
  - draws all five aliens after reset;
  - erases a killed alien's rectangle pixel by pixel;
  - shifts the surviving aliens down by one row per moveDown.
- Drives the VGA adapter's plot interface and returns the cleared1..cleared5 / clearedShift acknowledgements the manager waits on.

Parameters:
- WIDTH, 12, alien rectangle width minus one (x span inclusive: x..x+WIDTH).
- HEIGHT, 10, alien rectangle height minus one (y span inclusive).
- GAP, 20, horizontal gap between alien slots.
- START_X, 10, x of slot 0 left edge; slot i left edge = START_X + i*(WIDTH+GAP).
- START_Y, 10, initial top row of the alien band.
- Y_MAX, 119, last visible row.
- ALIEN_COLOUR, 3'b010, draw colour.
- BG_COLOUR, 3'b000, erase colour.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- kill1..kill5  in  1 each  kill request for slot 0..4; held high until the matching cleared is seen.
- moveDown  in  1  shift request; held high until clearedShift.
- alienTopX  in  8  left x of the rectangle to erase; valid on the first cycle of killN.
- alienTopY  in  7  top y of that rectangle.
- alienBottomX  in  8  right x (inclusive).
- alienBottomY  in  7  bottom y (inclusive).
- cleared1..cleared5  out  1 each  erase-complete acknowledgement.
- clearedShift  out  1  shift-complete acknowledgement.
- x  out  8  plot x.
- y  out  7  plot y.
- colour  out  3  plot colour.
- plot  out  1  write strobe, one pixel per cycle.
- alive  out  5  bit i = slot i still on screen.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=1 at posedge):
  - state=INIT_DRAW;
  - x, y, colour, plot, all cleared, clearedShift = 0;
  - alive=5'b11111;
  - yTop=START_Y;
  - pixel counters = 0.
- Reset mid-operation abandons the current rectangle immediately, with no further plot pulses.
- INIT_DRAW:
  - raster each slot 0..4, rows yTop..yTop+HEIGHT, columns left..left+WIDTH, row-major;
  - ALIEN_COLOUR, plot=1 every cycle;
  - 5*143=715 cycles, then IDLE.
- IDLE arbitration, evaluated each cycle, priority lowest kill index first, then moveDown:
  - A kill is accepted only if its cleared output is 0.
  - Accepting a kill latches all four coordinates that same cycle and goes to ERASE.
- ERASE:
  - raster the latched inclusive rectangle in BG_COLOUR, one pixel/cycle;
  - count = (BX-TX+1)*(BY-TY+1);
  - after the last pixel, clear alive[i] and go to ACK_KILL.
- ACK_KILL:
  - clearedN=1, held until killN=0 (four-phase handshake);
  - then clearedN=0 on the next edge and return to IDLE.
  - A kill of an already-dead slot still erases and acknowledges.
- SHIFT: for each slot 0..4 in order:
  - dead slot: 1 idle cycle, plot=0;
  - alive slot: erase row yTop (WIDTH+1 pixels, BG), then draw row yTop+HEIGHT+1 (WIDTH+1 pixels, ALIEN).
  - After slot 4, yTop increments by 1 and the state goes to ACK_SHIFT.
  - Saturation: if yTop+HEIGHT+1 > Y_MAX, no pixels are plotted, yTop is unchanged, and the state goes directly to ACK_SHIFT.
- ACK_SHIFT: clearedShift=1 until moveDown=0, then IDLE.
- Requests arriving while busy are not lost: they remain asserted and are arbitrated at the next IDLE.
- x/y/colour/plot are registered; a pixel's coordinates and plot=1 appear together. plot=0 outside raster cycles.
- Arithmetic:
  - x sums are 8-bit;
  - y sums are 7-bit, bounded by the saturation check;
  - counters wrap by explicit compare, never by overflow.

Test Plan:
- Release reset -> exactly 715 plot pulses, ALIEN_COLOUR. First pixel (10,10), last (150,20). Then busy=0, alive=11111.
- kill3 with TX=74,TY=10,BX=86,BY=20 -> 143 BG plots from (74,10) to (86,20), then cleared3=1. Hold kill3 5 more cycles -> cleared3 stays 1; drop it -> cleared3=0 the next cycle, alive=11011.
- moveDown with alive=11011, yTop=10:
  - 4*26 plots plus 1 skip cycle;
  - slot 0 erases (10..22,10) and draws (10..22,21);
  - clearedShift=1, yTop becomes 11.
- kill2 and moveDown asserted in the same IDLE cycle -> kill2 erase completes and is acknowledged first. After kill2 drops, the shift runs and skips slot 1.
- Assert reset on cycle 50 of an erase -> plot=0 on the next cycle, all cleared=0, alive=11111. INIT_DRAW restarts at (10,10).
- Force yTop to 109 (Y_MAX-HEIGHT), assert moveDown -> no plot pulses, clearedShift=1 within 2 cycles, yTop stays 109.

Source files
------------

// File: rtl/alien_clear_engine.sv
// Alien-row pixel engine: draws the five aliens after reset, erases killed
// aliens pixel by pixel and scrolls the survivors down one row per moveDown.
// All plot outputs are registered, so a pixel's coordinates, colour and plot
// strobe always appear together on the cycle after the engine chose them.
module alien_clear_engine #(
    parameter int WIDTH             = 12,
    parameter int HEIGHT            = 10,
    parameter int GAP               = 20,
    parameter int START_X           = 10,
    parameter int START_Y           = 10,
    parameter int Y_MAX             = 119,
    parameter logic [2:0] ALIEN_COLOUR = 3'b010,
    parameter logic [2:0] BG_COLOUR    = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kill1,
    input  logic       kill2,
    input  logic       kill3,
    input  logic       kill4,
    input  logic       kill5,
    input  logic       moveDown,
    input  logic [7:0] alienTopX,
    input  logic [6:0] alienTopY,
    input  logic [7:0] alienBottomX,
    input  logic [6:0] alienBottomY,
    output logic       cleared1,
    output logic       cleared2,
    output logic       cleared3,
    output logic       cleared4,
    output logic       cleared5,
    output logic       clearedShift,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [4:0] alive,
    output logic       busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);

    typedef enum logic [2:0] {
        INIT_DRAW,
        IDLE,
        ERASE,
        ACK_KILL,
        SHIFT,
        ACK_SHIFT
    } state_t;

    state_t state;
    state_t stateNext;

    // Raster counters shared by the initial draw and the shift sweep
    logic [2:0]    slot;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          shiftPhase;

    // Latched erase rectangle and the erase raster position
    logic [7:0] eraseX;
    logic [6:0] eraseY;
    logic [7:0] topX;
    logic [7:0] bottomX;
    logic [6:0] bottomY;
    logic [2:0] killIdx;

    logic [6:0] yTop;

    logic [4:0] killVec;
    logic [4:0] clearedReg;

    // Arbitration and raster-progress helpers
    logic       killFound;
    logic [2:0] killSel;
    logic       colLast;
    logic       rowLast;
    logic       slotLast;
    logic       initDone;
    logic       eraseXLast;
    logic       eraseYLast;
    logic       eraseDone;
    logic       shiftSat;
    logic       shiftSlotDone;
    logic       shiftDone;
    logic [7:0] drawX;
    logic [6:0] yRowNew;

    // Registered-output next values
    logic [7:0] xNext;
    logic [6:0] yNext;
    logic [2:0] colourNext;
    logic       plotNext;
    logic [4:0] clearedNext;
    logic       clearedShiftNext;

    function automatic logic [7:0] slotLeft(input logic [2:0] s);
        return 8'(START_X + int'(s) * (WIDTH + GAP));
    endfunction

    assign killVec  = {kill5, kill4, kill3, kill2, kill1};
    assign cleared1 = clearedReg[0];
    assign cleared2 = clearedReg[1];
    assign cleared3 = clearedReg[2];
    assign cleared4 = clearedReg[3];
    assign cleared5 = clearedReg[4];
    assign busy     = (state != IDLE);

    assign colLast    = (col == CW'(WIDTH));
    assign rowLast    = (row == RW'(HEIGHT));
    assign slotLast   = (slot == 3'd4);
    assign initDone   = colLast && rowLast && slotLast;
    assign eraseXLast = (eraseX == bottomX);
    assign eraseYLast = (eraseY == bottomY);
    assign eraseDone  = eraseXLast && eraseYLast;
    assign drawX      = slotLeft(slot) + 8'(col);
    assign yRowNew    = yTop + 7'(HEIGHT) + 7'd1;
    // The new bottom row must still be on screen, otherwise the band is parked
    assign shiftSat   = (yRowNew > 7'(Y_MAX));
    assign shiftSlotDone = !alive[slot] || (shiftPhase && colLast);
    assign shiftDone  = shiftSlotDone && slotLast;

    // Pick the lowest-numbered pending kill that has not yet been acknowledged
    always_comb begin
        killFound = 1'b0;
        killSel   = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (killVec[i] && !clearedReg[i]) begin
                killFound = 1'b1;
                killSel   = 3'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT_DRAW;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decisions: kills win over moveDown, handshakes are four-phase
    always_comb begin
        stateNext = state;
        case (state)
            INIT_DRAW: if (initDone) stateNext = IDLE;
            IDLE: begin
                if (killFound) begin
                    stateNext = ERASE;
                end else if (moveDown) begin
                    stateNext = shiftSat ? ACK_SHIFT : SHIFT;
                end
            end
            ERASE:     if (eraseDone) stateNext = ACK_KILL;
            ACK_KILL:  if (!killVec[killIdx]) stateNext = IDLE;
            SHIFT:     if (shiftDone) stateNext = ACK_SHIFT;
            ACK_SHIFT: if (!moveDown) stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // Output decode: the pixel this cycle's raster position produces, plus acks
    always_comb begin
        xNext            = x;
        yNext            = y;
        colourNext       = colour;
        plotNext         = 1'b0;
        clearedNext      = 5'b00000;
        clearedShiftNext = 1'b0;
        case (state)
            INIT_DRAW: begin
                plotNext   = 1'b1;
                xNext      = drawX;
                yNext      = yTop + 7'(row);
                colourNext = ALIEN_COLOUR;
            end
            IDLE: begin
                if (!killFound && moveDown && shiftSat) begin
                    clearedShiftNext = 1'b1;
                end
            end
            ERASE: begin
                plotNext   = 1'b1;
                xNext      = eraseX;
                yNext      = eraseY;
                colourNext = BG_COLOUR;
                if (eraseDone) begin
                    clearedNext[killIdx] = 1'b1;
                end
            end
            ACK_KILL: begin
                clearedNext[killIdx] = killVec[killIdx];
            end
            SHIFT: begin
                if (alive[slot]) begin
                    plotNext   = 1'b1;
                    xNext      = drawX;
                    yNext      = shiftPhase ? yRowNew : yTop;
                    colourNext = shiftPhase ? ALIEN_COLOUR : BG_COLOUR;
                end
                if (shiftDone) begin
                    clearedShiftNext = 1'b1;
                end
            end
            ACK_SHIFT: begin
                clearedShiftNext = moveDown;
            end
            default: begin
                plotNext = 1'b0;
            end
        endcase
    end

    // Plot interface and acknowledgement registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x            <= 8'd0;
            y            <= 7'd0;
            colour       <= 3'd0;
            plot         <= 1'b0;
            clearedReg   <= 5'b00000;
            clearedShift <= 1'b0;
        end else begin
            x            <= xNext;
            y            <= yNext;
            colour       <= colourNext;
            plot         <= plotNext;
            clearedReg   <= clearedNext;
            clearedShift <= clearedShiftNext;
        end
    end

    // Raster counters, latched rectangle, band position and alive mask
    always_ff @(posedge clk) begin
        if (reset) begin
            slot       <= 3'd0;
            col        <= '0;
            row        <= '0;
            shiftPhase <= 1'b0;
            eraseX     <= 8'd0;
            eraseY     <= 7'd0;
            topX       <= 8'd0;
            bottomX    <= 8'd0;
            bottomY    <= 7'd0;
            killIdx    <= 3'd0;
            yTop       <= 7'(START_Y);
            alive      <= 5'b11111;
        end else begin
            case (state)
                INIT_DRAW: begin
                    if (colLast) begin
                        col <= '0;
                        if (rowLast) begin
                            row  <= '0;
                            slot <= slotLast ? 3'd0 : slot + 3'd1;
                        end else begin
                            row <= row + RW'(1);
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                IDLE: begin
                    if (killFound) begin
                        killIdx <= killSel;
                        eraseX  <= alienTopX;
                        eraseY  <= alienTopY;
                        topX    <= alienTopX;
                        bottomX <= alienBottomX;
                        bottomY <= alienBottomY;
                    end else if (moveDown && !shiftSat) begin
                        slot       <= 3'd0;
                        col        <= '0;
                        shiftPhase <= 1'b0;
                    end
                end
                ERASE: begin
                    if (eraseXLast) begin
                        eraseX <= topX;
                        if (eraseYLast) begin
                            alive[killIdx] <= 1'b0;
                        end else begin
                            eraseY <= eraseY + 7'd1;
                        end
                    end else begin
                        eraseX <= eraseX + 8'd1;
                    end
                end
                SHIFT: begin
                    if (shiftSlotDone) begin
                        col        <= '0;
                        shiftPhase <= 1'b0;
                        if (slotLast) begin
                            slot <= 3'd0;
                            yTop <= yTop + 7'd1;
                        end else begin
                            slot <= slot + 3'd1;
                        end
                    end else if (colLast) begin
                        col        <= '0;
                        shiftPhase <= 1'b1;
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                default: begin
                    slot <= slot;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alien_clear_engine.sv
// Self-checking bench for alien_clear_engine: initial draw, kill erase with
// four-phase ack, shifting, kill/moveDown priority, mid-erase reset and
// bottom-of-screen saturation.
module tb_alien_clear_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] killBus;
    logic       moveDown;
    logic [7:0] alienTopX;
    logic [6:0] alienTopY;
    logic [7:0] alienBottomX;
    logic [6:0] alienBottomY;
    logic       cleared1, cleared2, cleared3, cleared4, cleared5;
    logic       clearedShift;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [4:0] alive;
    logic       busy;
    logic [4:0] clearedBus;

    assign clearedBus = {cleared5, cleared4, cleared3, cleared2, cleared1};

    alien_clear_engine dut (
        .clk          (clk),
        .reset        (reset),
        .kill1        (killBus[0]),
        .kill2        (killBus[1]),
        .kill3        (killBus[2]),
        .kill4        (killBus[3]),
        .kill5        (killBus[4]),
        .moveDown     (moveDown),
        .alienTopX    (alienTopX),
        .alienTopY    (alienTopY),
        .alienBottomX (alienBottomX),
        .alienBottomY (alienBottomY),
        .cleared1     (cleared1),
        .cleared2     (cleared2),
        .cleared3     (cleared3),
        .cleared4     (cleared4),
        .cleared5     (cleared5),
        .clearedShift (clearedShift),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .alive        (alive),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        int         tx;
        int         ty;
        int         bx;
        int         by;
        int         expCount;
        logic [4:0] expAlive;
        int         hold;
    } killVec_t;

    int checks = 0;
    int passes = 0;

    // Plot monitor state, cleared before each phase
    int         plotCnt;
    int         bgCnt;
    int         alienCnt;
    int         busyCyc;
    bit         gotFirst;
    bit         gotAlien;
    logic [7:0] firstX, lastX, firstAX;
    logic [6:0] firstY, lastY, firstAY;

    function automatic int xy(input int px, input int py);
        return px * 256 + py;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clearMonitor();
        plotCnt  = 0;
        bgCnt    = 0;
        alienCnt = 0;
        busyCyc  = 0;
        gotFirst = 1'b0;
        gotAlien = 1'b0;
        firstX = 0; firstY = 0; lastX = 0; lastY = 0; firstAX = 0; firstAY = 0;
    endtask

    // Record every plotted pixel and the busy cycles before any ack rises
    always @(negedge clk) begin
        if (!reset) begin
            if (plot) begin
                plotCnt++;
                if (colour == 3'b000) bgCnt++;
                if (colour == 3'b010) alienCnt++;
                if (!gotFirst) begin
                    gotFirst = 1'b1;
                    firstX = x;
                    firstY = y;
                end
                if (colour == 3'b010 && !gotAlien) begin
                    gotAlien = 1'b1;
                    firstAX = x;
                    firstAY = y;
                end
                lastX = x;
                lastY = y;
            end
            if (busy && clearedBus == 5'b00000 && !clearedShift) busyCyc++;
        end
    end

    // Run one kill request through erase and four-phase ack
    task automatic applyStimulus(input killVec_t v);
        int  n;
        bit  holdOk;
        clearMonitor();
        alienTopX    = 8'(v.tx);
        alienTopY    = 7'(v.ty);
        alienBottomX = 8'(v.bx);
        alienBottomY = 7'(v.by);
        killBus[v.idx] = 1'b1;
        n = 0;
        while (clearedBus[v.idx] !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        checkOutput($sformatf("kill%0d_ack", v.idx + 1), int'(clearedBus[v.idx]), 1);
        checkOutput($sformatf("kill%0d_plots", v.idx + 1), plotCnt, v.expCount);
        checkOutput($sformatf("kill%0d_bg_plots", v.idx + 1), bgCnt, v.expCount);
        checkOutput($sformatf("kill%0d_first_xy", v.idx + 1), xy(firstX, firstY), xy(v.tx, v.ty));
        checkOutput($sformatf("kill%0d_last_xy", v.idx + 1), xy(lastX, lastY), xy(v.bx, v.by));
        checkOutput($sformatf("kill%0d_busy_cycles", v.idx + 1), busyCyc, v.expCount);
        if (v.hold > 0) begin
            holdOk = 1'b1;
            for (int i = 0; i < v.hold; i++) begin
                tick();
                if (clearedBus[v.idx] !== 1'b1 || plot !== 1'b0) holdOk = 1'b0;
            end
            checkOutput($sformatf("kill%0d_ack_held", v.idx + 1), int'(holdOk), 1);
        end
        killBus[v.idx] = 1'b0;
        tick();
        checkOutput($sformatf("kill%0d_ack_drop", v.idx + 1), int'(clearedBus), 0);
        checkOutput($sformatf("kill%0d_alive", v.idx + 1), int'(alive), int'(v.expAlive));
        checkOutput($sformatf("kill%0d_idle", v.idx + 1), int'(busy), 0);
    endtask

    // Run one moveDown through the sweep and check its pixel footprint
    task automatic runShift(input string tag, input int expBg, input int expAlien,
                            input int fx, input int fy, input int ax, input int ay,
                            input int lx, input int ly, input int expBusy);
        int n;
        clearMonitor();
        moveDown = 1'b1;
        n = 0;
        while (clearedShift !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        checkOutput({tag, "_ack"}, int'(clearedShift), 1);
        checkOutput({tag, "_bg_plots"}, bgCnt, expBg);
        checkOutput({tag, "_alien_plots"}, alienCnt, expAlien);
        checkOutput({tag, "_first_xy"}, xy(firstX, firstY), xy(fx, fy));
        checkOutput({tag, "_first_alien_xy"}, xy(firstAX, firstAY), xy(ax, ay));
        checkOutput({tag, "_last_xy"}, xy(lastX, lastY), xy(lx, ly));
        checkOutput({tag, "_cycles"}, busyCyc, expBusy);
        moveDown = 1'b0;
        tick();
        checkOutput({tag, "_ack_drop"}, int'(clearedShift), 0);
    endtask

    task automatic waitInitDraw(input string tag);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        checkOutput({tag, "_done"}, int'(busy), 0);
        checkOutput({tag, "_plots"}, plotCnt, 715);
        checkOutput({tag, "_alien_plots"}, alienCnt, 715);
        checkOutput({tag, "_first_xy"}, xy(firstX, firstY), xy(10, 10));
        checkOutput({tag, "_last_xy"}, xy(lastX, lastY), xy(150, 20));
        checkOutput({tag, "_alive"}, int'(alive), 5'b11111);
    endtask

    initial begin
        killVec_t table_v[5];
        killVec_t k3;
        int       n;
        int       totalPlots;
        bit       allAcked;

        table_v[0] = '{1, 42,  10, 54,  20, 143, 5'b11101, 0};
        table_v[1] = '{2, 74,  10, 86,  20, 143, 5'b11001, 0};
        table_v[2] = '{3, 106, 10, 118, 20, 143, 5'b10001, 0};
        table_v[3] = '{4, 138, 10, 150, 20, 143, 5'b00001, 0};
        table_v[4] = '{2, 74,  10, 75,  12, 6,   5'b00001, 0};

        reset = 1'b1;
        killBus = 5'b00000;
        moveDown = 1'b0;
        alienTopX = 0; alienTopY = 0; alienBottomX = 0; alienBottomY = 0;
        clearMonitor();
        repeat (3) tick();

        // Reset state
        checkOutput("rst_plot", int'(plot), 0);
        checkOutput("rst_xy", xy(x, y), 0);
        checkOutput("rst_colour", int'(colour), 0);
        checkOutput("rst_cleared", int'(clearedBus), 0);
        checkOutput("rst_cleared_shift", int'(clearedShift), 0);
        checkOutput("rst_alive", int'(alive), 5'b11111);
        checkOutput("rst_busy", int'(busy), 1);

        clearMonitor();
        reset = 1'b0;
        waitInitDraw("init");

        // kill3 with an extended hold of the request
        k3 = '{2, 74, 10, 86, 20, 143, 5'b11011, 5};
        applyStimulus(k3);

        // First shift from yTop=10 with slot 2 dead
        runShift("shift1", 52, 52, 10, 10, 10, 21, 150, 21, 105);

        // kill2 and moveDown together: the kill is served first
        clearMonitor();
        alienTopX = 8'd42; alienTopY = 7'd11; alienBottomX = 8'd54; alienBottomY = 7'd21;
        killBus[1] = 1'b1;
        moveDown = 1'b1;
        n = 0;
        while (cleared2 !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        checkOutput("prio_kill2_ack", int'(cleared2), 1);
        checkOutput("prio_shift_waits", int'(clearedShift), 0);
        checkOutput("prio_kill2_bg_plots", bgCnt, 143);
        checkOutput("prio_kill2_last_xy", xy(lastX, lastY), xy(54, 21));
        killBus[1] = 1'b0;
        runShift("shift2", 39, 39, 10, 11, 10, 22, 150, 22, 80);
        checkOutput("shift2_alive", int'(alive), 5'b11001);

        // Reset 50 pixels into an erase
        clearMonitor();
        alienTopX = 8'd10; alienTopY = 7'd12; alienBottomX = 8'd22; alienBottomY = 7'd22;
        killBus[0] = 1'b1;
        n = 0;
        while (plotCnt < 50 && n < 500) begin
            tick();
            n++;
        end
        checkOutput("mid_erase_plots", plotCnt, 50);
        reset = 1'b1;
        killBus[0] = 1'b0;
        tick();
        checkOutput("mid_rst_plot", int'(plot), 0);
        checkOutput("mid_rst_cleared", int'(clearedBus), 0);
        checkOutput("mid_rst_alive", int'(alive), 5'b11111);
        checkOutput("mid_rst_busy", int'(busy), 1);
        clearMonitor();
        reset = 1'b0;
        waitInitDraw("reinit");

        // Table of kills leaving only slot 0 alive, including a dead-slot kill
        for (int i = 0; i < 5; i++) begin
            applyStimulus(table_v[i]);
        end

        // Walk the band down to the bottom of the screen
        totalPlots = 0;
        allAcked = 1'b1;
        for (int s = 0; s < 99; s++) begin
            clearMonitor();
            moveDown = 1'b1;
            n = 0;
            while (clearedShift !== 1'b1 && n < 200) begin
                tick();
                n++;
            end
            if (clearedShift !== 1'b1) allAcked = 1'b0;
            totalPlots += plotCnt;
            moveDown = 1'b0;
            tick();
        end
        checkOutput("walk_acks", int'(allAcked), 1);
        checkOutput("walk_plots", totalPlots, 99 * 26);
        checkOutput("walk_last_xy", xy(lastX, lastY), xy(22, 119));
        checkOutput("walk_ytop", int'(dut.yTop), 109);

        // Saturated shift: no pixels, fast ack, band stays put
        clearMonitor();
        moveDown = 1'b1;
        n = 0;
        while (clearedShift !== 1'b1 && n < 2) begin
            tick();
            n++;
        end
        checkOutput("sat_ack", int'(clearedShift), 1);
        checkOutput("sat_plots", plotCnt, 0);
        checkOutput("sat_ytop", int'(dut.yTop), 109);
        moveDown = 1'b0;
        tick();
        checkOutput("sat_ack_drop", int'(clearedShift), 0);
        checkOutput("sat_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
